// File: rtl/data_memory_responder_if.sv
// Data-memory command bus between the memory stage (master) and the responder (slave).
interface data_memory_responder_if;
  logic        mem_cmd_start;
  logic        mem_cmd_write;
  logic        mem_cmd_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_misalign_err;

  modport master (
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid, mem_misalign_err
  );

  modport slave (
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid, mem_misalign_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Word-organised RAM behind the data-memory command bus, one command in flight at a time.
// Optional misalignment trap: define DATA_MEMORY_RESPONDER_MISALIGN_TRAP_EN.
module data_memory_responder #(
  parameter int ADDR_WIDTH    = 12,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 0
) (
  input  logic clk,
  input  logic rst,
  data_memory_responder_if.slave bus
);
`ifdef DATA_MEMORY_RESPONDER_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int MAXL = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_WAIT, RD_RESP} state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           rdata_q, hold_q;
  logic                  valid_q, err_q, herr_q;
  logic [31:0]           mem_q [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            off;
  logic [4:0]            sh;
  logic                  accept, misaligned, mis_trap;
  logic [31:0]           wm_sh, wd_sh, fresh;
  logic                  unused_addr;

  assign idx         = bus.mem_addr[ADDR_WIDTH+1:2];
  assign off         = bus.mem_addr[1:0];
  assign sh          = {off, 3'b000};
  assign unused_addr = ^bus.mem_addr[31:ADDR_WIDTH+2];
  assign accept      = bus.mem_cmd_start && (state_q == IDLE);

  assign misaligned  = ((bus.mem_wmask == 32'h0000_ffff) && off[0]) ||
                       ((bus.mem_wmask == 32'hffff_ffff) && (off != 2'd0));
  assign mis_trap    = TRAP_EN && misaligned;

  // Lanes pushed past bit 31 by the offset simply fall off.
  assign wm_sh = bus.mem_wmask << sh;
  assign wd_sh = bus.mem_wdata << sh;
  assign fresh = mis_trap ? 32'hffff_ffff : ((mem_q[idx] >> sh) & bus.mem_wmask);

  always_ff @(posedge clk) begin
    if (!rst && accept && bus.mem_cmd_write && !mis_trap)
      mem_q[idx] <= (mem_q[idx] & ~wm_sh) | (wd_sh & wm_sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      herr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (bus.mem_cmd_write) begin
            err_q <= mis_trap;
            if (WRITE_LATENCY > 0) begin
              state_q <= WR_BUSY;
              cnt_q   <= CW'(WRITE_LATENCY - 1);
            end
          end else if (READ_LATENCY == 1) begin
            state_q <= RD_RESP;
            rdata_q <= fresh;
            valid_q <= 1'b1;
            err_q   <= mis_trap;
          end else begin
            state_q <= RD_WAIT;
            cnt_q   <= CW'(READ_LATENCY - 2);
            hold_q  <= fresh;
            herr_q  <= mis_trap;
          end
        end
        WR_BUSY: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        RD_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RD_RESP;
            rdata_q <= hold_q;
            valid_q <= 1'b1;
            err_q   <= herr_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_cmd_ready    = (state_q == IDLE);
  assign bus.mem_rdata        = rdata_q;
  assign bus.mem_rdata_valid  = valid_q;
  assign bus.mem_misalign_err = err_q;
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data-memory command interface (`mem_cmd_start` / `mem_cmd_ready` / `mem_rdata_valid`), the port the memory stage drives for loads and stores.

- Backs the interface with a word-organised on-chip RAM.
- Accepts one command at a time and holds `mem_cmd_ready` low while a command is in flight.
- Returns load data aligned to bit 0; loads are sign/zero-extended by the stage.
- Sits between the memory stage and the data RAM; replaces the ideal memory model in core-level simulation.

## Interface
- `ADDR_WIDTH`, default 12: word-index bits. The RAM holds 2^ADDR_WIDTH 32-bit words.
- `READ_LATENCY`, default 2, minimum 1: cycles from read acceptance to `mem_rdata_valid`.
- `WRITE_LATENCY`, default 0: busy cycles after write acceptance before `mem_cmd_ready` returns.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_cmd_start` in 1: command request.
- `mem_cmd_write` in 1: 1 = store, 0 = load; qualified by `mem_cmd_start`.
- `mem_cmd_ready` out 1: responder can accept a command this cycle.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, low-aligned.
- `mem_wmask` in 32: bit mask, low-aligned. Encodings: 0x000000ff (byte), 0x0000ffff (half), 0xffffffff (word).
- `mem_rdata` out 32: load data, shifted so the addressed byte is at bit 0.
- `mem_rdata_valid` out 1: one-cycle pulse marking `mem_rdata` valid.
- `mem_misalign_err` out 1: misalignment flag (see Configuration).

## Operation
- Word index = `mem_addr[ADDR_WIDTH+1:2]`; offset = `mem_addr[1:0]`. Upper address bits are ignored, so addresses wrap.
- A command is accepted in any cycle where `mem_cmd_start && mem_cmd_ready`.
- Captured on acceptance: offset, word index, `mem_wmask`.
- `mem_cmd_ready` is a pure function of registered state, so it never depends on `mem_cmd_start` in the same cycle.
- States:
  - IDLE: ready = 1.
  - WR_BUSY: ready = 0.
  - RD_WAIT: ready = 0; latency counter running.
  - RD_RESP: ready = 0; `mem_rdata_valid` = 1.
- Store:
  - The RAM word is updated at the accepting edge. Bit i is replaced where `(mem_wmask << 8*offset)[i]` is 1, taking `(mem_wdata << 8*offset)[i]`.
  - Bits shifted past bit 31 are dropped.
  - Next state: IDLE if `WRITE_LATENCY` = 0, otherwise WR_BUSY for `WRITE_LATENCY` cycles, then IDLE.
- Load:
  - The word is read at acceptance and held.
  - Go to RD_WAIT. After `READ_LATENCY`-1 cycles go to RD_RESP (RD_WAIT is skipped when latency is 1).
  - `mem_rdata` = word >> 8*offset, zero-filled, then masked with the captured `mem_wmask`.
  - RD_RESP lasts exactly one cycle, then IDLE.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data.
- `mem_cmd_start` asserted while ready = 0 is ignored. No queuing.

## Timing
- Reset values:
  - state = IDLE, so `mem_cmd_ready` = 1 in the first cycle after reset.
  - `mem_rdata` = 0x00000000.
  - `mem_rdata_valid` = 0, `mem_misalign_err` = 0.
  - Latency counter = 0.
  - RAM contents are not reset.
- Load accepted at edge T:
  - `mem_rdata_valid` = 1 in cycle T+`READ_LATENCY` only.
  - `mem_cmd_ready` = 0 from cycle T+1 through T+`READ_LATENCY`, and 1 at T+`READ_LATENCY`+1.
- Store accepted at edge T: `mem_cmd_ready` = 0 in cycles T+1 through T+`WRITE_LATENCY`.
- `mem_rdata` holds its last value outside RD_RESP. Consumers qualify it with `mem_rdata_valid`.
- Reset during a command: the command is dropped, no `mem_rdata_valid` pulse is produced, and the responder is ready in the next cycle.
  - A store accepted in the same cycle as `rst` is not performed.

## Configuration
- Macro: `DATA_MEMORY_RESPONDER_MISALIGN_TRAP_EN`.
- Misaligned means either of:
  - `mem_wmask` = 0x0000ffff with offset[0] = 1;
  - `mem_wmask` = 0xffffffff with offset ≠ 0.
- Defined: misaligned commands are still handshaken with normal timing, but:
  - a misaligned store does not modify the RAM;
  - a misaligned load returns 0xffffffff;
  - `mem_misalign_err` pulses together with `mem_rdata_valid` for a load;
  - for a store, it pulses in the cycle after acceptance.
- Undefined: misaligned accesses proceed with the truncation rules above, and `mem_misalign_err` is tied to 0.

## Test plan
- Reset, then store word 0x12345678 at address 0x100, then load at 0x100 → ready = 1 after reset; `mem_rdata_valid` exactly `READ_LATENCY` cycles after load acceptance; `mem_rdata` = 0x12345678.
- Store byte 0xAB (mask 0xff) at 0x101 over word 0x12345678, then load byte at 0x101 and word at 0x100 → 0x000000AB, then 0x1234AB78.
- Back-to-back: store accepted at cycle T, load of the same word accepted at T+1 (`WRITE_LATENCY` = 0) → load returns the new data; ready = 0 during the read.
- Hold `mem_cmd_start` high through a read with `READ_LATENCY` = 3 → no extra command is accepted; the next acceptance is exactly at T+4.
- Assert `rst` in the cycle after a load is accepted → no `mem_rdata_valid`; ready = 1 in the next cycle.
- With the macro defined: store half at 0x103 → RAM unchanged and `mem_misalign_err` pulses. Load word at 0x102 → 0xffffffff with the err pulse.
- Without the macro: same store → err = 0 and RAM byte 3 is written.
